regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32x32 register file between the in-order pipeline writeback stage and a long-latency unit (multiplier/divider/load return). Pipeline writebacks have absolute priority; long-latency results are buffered in a small FIFO and drained into idle write slots. An optional scoreboard tracks registers with outstanding long-latency results so the hazard unit can stall dependent reads. It sits between WB/long-latency unit and the register file write inputs (RegWrite, write_reg, write_data).

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, long-latency buffer entries (power of two, >=2)
- STARVE_MAX, 8, cycles a non-empty FIFO may be blocked before stall request
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- wb_valid  input  1  pipeline writeback request; always accepted
- wb_addr  input  ADDR_W  pipeline destination register
- wb_data  input  DATA_W  pipeline result
- lu_valid  input  1  long-latency result valid
- lu_ready  output  1  FIFO can accept; transfer when lu_valid & lu_ready
- lu_addr  input  ADDR_W  long-latency destination register
- lu_data  input  DATA_W  long-latency result
- issue_valid  input  1  long-latency op issued; marks issue_addr pending
- issue_addr  input  ADDR_W  destination of issued op
- chk_addr1, chk_addr2  input  ADDR_W  source registers of decoding instruction
- busy1, busy2  output  1  chk_addrN has an outstanding long-latency result
- stall_req  output  1  request pipeline bubble to drain FIFO
- rf_we, rf_waddr, rf_wdata  output  1/ADDR_W/DATA_W  to register file RegWrite/write_reg/write_data

## Operation
- Reset: FIFO empty, pending vector 0, starve counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0; lu_ready=1, busy1/busy2=0.
- Slot selection per cycle: if wb_valid and wb_addr!=0 -> WB wins; else if FIFO non-empty -> pop head; else no write.
- Writes to address 0 are discarded (never reach rf_we); a wb_valid with wb_addr=0 counts as an idle slot. Pushes with lu_addr=0 are accepted and dropped at pop (no write, pending untouched).
- FIFO: lu_ready = !full. Push and pop in the same cycle allowed, including when full (lu_ready stays low when full; no push when full). Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- Scoreboard: 32-bit pending vector. issue_valid with issue_addr!=0 sets bit. A FIFO pop to address A clears bit A on the edge the register file captures the data. Set and clear of same address in same edge: set wins. busyN = pending[chk_addrN], combinational; chk_addrN=0 -> 0.
- WAW between WB and pending LU is not blocked: both writes occur in arrival order; pending stays set until LU write.
- Starvation: counter increments each cycle FIFO is non-empty and not popped; clears on any pop or when empty. stall_req registered, asserts when counter reaches STARVE_MAX, deasserts the edge after the next pop. WB still has priority while stall_req=1; no data is ever lost.

## Timing
- Selection combinational; rf_we/rf_waddr/rf_wdata registered: request in cycle N -> outputs valid cycle N+1 -> register file written at edge ending N+1.
- lu transfer in cycle N on empty FIFO with no WB -> earliest rf_we in N+2.
- Pending bit clears at same edge register file captures data; reader in following cycle sees new value with busy=0.
- Reset asserted mid-operation: FIFO contents and pending bits discarded, rf_we drops immediately (asynchronous).

## Configuration
- RFARB_SCOREBOARD_EN defined: pending vector, busy1/busy2 as above.
- Undefined: no pending storage; busy1/busy2 tied 0; issue_valid/issue_addr ignored. Arbitration, FIFO, starvation unchanged.

## Structure
- Package rfarb_pkg: DATA_W, ADDR_W, FIFO_DEPTH, STARVE_MAX defaults; typedef for write request {addr, data}.
- Sub-module rfarb_fifo: synchronous FIFO with push/pop/full/empty/count, async active-low reset.

## Test plan
- Reset then wb_valid=1, wb_addr=3, wb_data=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234.
- wb_valid=1 every cycle, push 4 LU results -> lu_ready=0 after 4th; no rf write from FIFO; stall_req=1 after 8 blocked cycles; drop wb_valid -> head popped, stall_req falls next edge.
- Simultaneous wb (r5,0xA) and lu (r6,0xB) on empty FIFO -> r5 written cycle+1, r6 cycle+2.
- issue r7, chk_addr1=7 -> busy1=1; LU result r7 accepted -> busy1 falls the cycle after rf_we for r7; same-edge re-issue of r7 keeps busy1=1.
- wb_addr=0 and lu_addr=0 requests -> rf_we never asserts; FIFO slot freed.
- Reset asserted with 3 FIFO entries and pending r9 -> empty FIFO, lu_ready=1, busy for r9 =0, rf_we=0.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared defaults and the write-request record for the register-file write arbiter.
package rfarb_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/rfarb_fifo.sv
// Small synchronous FIFO buffering long-latency write results; push is ignored when full,
// pop is ignored when empty, and push/pop may occur together.
module rfarb_fifo
    import rfarb_pkg::*;
#(
    parameter int WIDTH = ADDR_W + DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and buffered
// long-latency results. Define RFARB_SCOREBOARD_EN to enable the pending-register scoreboard.
module regfile_write_arbiter
    import rfarb_pkg::*;
#(
    parameter int DATA_W     = rfarb_pkg::DATA_W,
    parameter int ADDR_W     = rfarb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = rfarb_pkg::FIFO_DEPTH,
    parameter int STARVE_MAX = rfarb_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(STARVE_MAX + 1);
    localparam int REQ_W    = ADDR_W + DATA_W;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic [REQ_W-1:0]  head_req;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              wb_take;
    logic              pop_sel;
    logic              push;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_next;

    assign {head_addr, head_data} = head_req;

    // A writeback to r0 is a free slot, so it does not block draining.
    assign wb_take  = wb_valid && (wb_addr != '0);
    assign pop_sel  = !wb_take && !fifo_empty;
    assign push     = lu_valid && !fifo_full;
    assign lu_ready = !fifo_full;

    rfarb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop_sel),
        .din   ({lu_addr, lu_data}),
        .dout  (head_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_take) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
        end else if (pop_sel && (head_addr != '0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if ((fifo_count == '0) || pop_sel) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == STARVE_LIM);
        end
    end

`ifdef RFARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                rf_from_lu;

    // Clear lands on the edge the register file captures the LU write; a same-edge issue wins.
    always_comb begin
        pending_next = pending;
        if (rf_we && rf_from_lu) begin
            pending_next[rf_waddr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            rf_from_lu <= 1'b0;
        end else begin
            pending    <= pending_next;
            rf_from_lu <= pop_sel && (head_addr != '0);
        end
    end

    assign busy1 = (chk_addr1 != '0) && pending[chk_addr1];
    assign busy2 = (chk_addr2 != '0) && pending[chk_addr2];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_addr, chk_addr1, chk_addr2};
    assign busy1     = 1'b0;
    assign busy2     = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, corner sequences, random traffic
// compared against a queue-based reference model.
module tb_regfile_write_arbiter;
    import rfarb_pkg::*;

`ifdef RFARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              busy1;
    logic              busy2;
    logic              stall_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_addr     (lu_addr),
        .lu_data     (lu_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .busy1       (busy1),
        .busy2       (busy2),
        .stall_req   (stall_req),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Reference model: queue of buffered results, pending flags, run length of blocked cycles.
    wr_req_t           m_q[$];
    logic [31:0]       m_pend;
    int                m_blocked;
    logic              m_we;
    logic              m_we_lu;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              wb_v;
        logic [ADDR_W-1:0] wb_a;
        logic [DATA_W-1:0] wb_d;
        logic              lu_v;
        logic [ADDR_W-1:0] lu_a;
        logic [DATA_W-1:0] lu_d;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend    = '0;
        m_blocked = 0;
        m_we      = 1'b0;
        m_we_lu   = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_stall   = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        lu_valid    = 1'b0;
        lu_addr     = '0;
        lu_data     = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic applyStimulus();
        logic    take;
        logic    pop;
        int      pre_size;
        wr_req_t h;
        h = '0;
        #1;
        chk_bit("lu_ready", lu_ready, m_q.size() < FIFO_DEPTH);
        chk_bit("busy1", busy1, (chk_addr1 != '0) && m_pend[chk_addr1]);
        chk_bit("busy2", busy2, (chk_addr2 != '0) && m_pend[chk_addr2]);

        pre_size = m_q.size();
        take     = wb_valid && (wb_addr != '0);
        pop      = !take && (pre_size > 0);
        if (m_we && m_we_lu) m_pend[m_addr] = 1'b0;
        if (SB && issue_valid && (issue_addr != '0)) m_pend[issue_addr] = 1'b1;
        if (pop) h = m_q.pop_front();
        if (lu_valid && (pre_size < FIFO_DEPTH)) m_q.push_back('{addr: lu_addr, data: lu_data});
        if (take) begin
            m_we = 1'b1; m_we_lu = 1'b0; m_addr = wb_addr; m_data = wb_data;
        end else if (pop && (h.addr != '0)) begin
            m_we = 1'b1; m_we_lu = 1'b1; m_addr = h.addr; m_data = h.data;
        end else begin
            m_we = 1'b0; m_we_lu = 1'b0;
        end
        if (pop || (pre_size == 0)) m_blocked = 0;
        else m_blocked++;
        m_stall = (m_blocked >= STARVE_MAX);

        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic checkOutput();
        chk_bit("rf_we", rf_we, m_we);
        if (m_we) begin
            chk32("rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk32("rf_wdata", rf_wdata, m_data);
        end
        chk_bit("stall_req", stall_req, m_stall);
    endtask

    initial begin
        rst       = 1'b0;
        chk_addr1 = 5'd5;
        chk_addr2 = '0;
        idle_inputs();
        model_reset();

        vecs[0] = '{1'b1, 5'd3,  32'h1234, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3,  32'h1234};
        vecs[1] = '{1'b1, 5'd5,  32'hA,    1'b1, 5'd6, 32'hB,  1'b1, 5'd5,  32'hA};
        vecs[2] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 5'd6,  32'hB};
        vecs[3] = '{1'b1, 5'd0,  32'hDEAD, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};
        vecs[6] = '{1'b1, 5'd9,  32'h99,   1'b1, 5'd8, 32'h88, 1'b1, 5'd9,  32'h99};
        vecs[7] = '{1'b1, 5'd10, 32'h100,  1'b0, 5'd0, 32'h0,  1'b1, 5'd10, 32'h100};
        vecs[8] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 5'd8,  32'h88};
        vecs[9] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};

        @(negedge clk);
        #1;
        chk_bit("reset_rf_we", rf_we, 1'b0);
        chk32("reset_rf_waddr", 32'(rf_waddr), 32'h0);
        chk32("reset_rf_wdata", rf_wdata, 32'h0);
        chk_bit("reset_stall", stall_req, 1'b0);
        chk_bit("reset_lu_ready", lu_ready, 1'b1);
        chk_bit("reset_busy1", busy1, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wb_valid = vecs[i].wb_v; wb_addr = vecs[i].wb_a; wb_data = vecs[i].wb_d;
            lu_valid = vecs[i].lu_v; lu_addr = vecs[i].lu_a; lu_data = vecs[i].lu_d;
            applyStimulus();
            chk_bit($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk32($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].e_addr));
                chk32($sformatf("vec%0d_data", i), rf_wdata, vecs[i].e_data);
            end
        end

        // Starvation: continuous writebacks with a filling FIFO.
        for (int k = 0; k < 9; k++) begin
            wb_valid = 1'b1; wb_addr = 5'd1 + 5'(k % 4); wb_data = 32'(k);
            lu_valid = 1'b1; lu_addr = 5'd11 + 5'(k); lu_data = 32'h500 + 32'(k);
            applyStimulus();
            if (k == 3) chk_bit("full_lu_ready", lu_ready, 1'b0);
        end
        chk_bit("starve_stall_high", stall_req, 1'b1);
        idle_inputs();
        applyStimulus();
        chk_bit("starve_stall_low", stall_req, 1'b0);
        chk32("starve_first_pop", 32'(rf_waddr), 32'd11);
        for (int k = 0; k < 4; k++) applyStimulus();

        // Scoreboard: issue, complete, and same-edge re-issue of r7.
        chk_addr1 = 5'd7;
        issue_valid = 1'b1; issue_addr = 5'd7;
        applyStimulus();
        idle_inputs();
        chk_bit("sb_busy_after_issue", busy1, SB);
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h7777;
        applyStimulus();
        idle_inputs();
        applyStimulus();
        chk_bit("sb_r7_written", rf_we, 1'b1);
        chk_bit("sb_busy_during_write", busy1, SB);
        issue_valid = 1'b1; issue_addr = 5'd7;
        applyStimulus();
        idle_inputs();
        chk_bit("sb_reissue_keeps_busy", busy1, SB);
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h7778;
        applyStimulus();
        idle_inputs();
        applyStimulus();
        applyStimulus();
        chk_bit("sb_busy_cleared", busy1, 1'b0);

        // Asynchronous reset with buffered entries and a pending register.
        chk_addr1 = 5'd9;
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hC0 + 32'(k);
            lu_valid = 1'b1; lu_addr = 5'd21 + 5'(k); lu_data = 32'hD0 + 32'(k);
            issue_valid = (k == 0); issue_addr = 5'd9;
            applyStimulus();
        end
        idle_inputs();
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hEE;
        applyStimulus();
        idle_inputs();
        #3 rst = 1'b0;
        #1;
        chk_bit("async_rst_rf_we", rf_we, 1'b0);
        chk_bit("async_rst_lu_ready", lu_ready, 1'b1);
        chk_bit("async_rst_busy_r9", busy1, 1'b0);
        chk_bit("async_rst_stall", stall_req, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wb_valid    = ($urandom_range(0, 99) < 55);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            lu_valid    = ($urandom_range(0, 99) < 40);
            lu_addr     = 5'($urandom_range(0, 7));
            lu_data     = $urandom;
            issue_valid = ($urandom_range(0, 99) < 20);
            issue_addr  = 5'($urandom_range(0, 7));
            chk_addr1   = 5'($urandom_range(0, 7));
            chk_addr2   = 5'($urandom_range(0, 7));
            applyStimulus();
        end
        idle_inputs();
        for (int k = 0; k < 12; k++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
